// File: rtl/irq_ctrl_if.sv
// Peripheral bus bundle for the interrupt controller register block.
//   addr_ip  : register address
//   data_ip  : write data
//   wr_en_ip : write strobe
//   rd_en_ip : read strobe
//   data_op  : read data, combinational from addr_ip
// The master side (bus owner) drives address, data and strobes and
// receives read data. The slave side is the register block.
interface irq_ctrl_if;
  logic [7:0] addr_ip;
  logic [7:0] data_ip;
  logic       wr_en_ip;
  logic       rd_en_ip;
  logic [7:0] data_op;

  modport master (output addr_ip, data_ip, wr_en_ip, rd_en_ip, input data_op);
  modport slave  (input addr_ip, data_ip, wr_en_ip, rd_en_ip, output data_op);
endinterface

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller with a nesting context stack.
// Ports:
//   clk_ip, reset_ip     : clock and asynchronous active-high reset
//   irq_ip               : asynchronous rising-edge interrupt pins
//   bus                  : peripheral register bus (IE, PEND, CTRL)
//   irq_req_op/vec_op    : registered request and vector to the CPU
//   irq_ack_ip           : CPU takes the request; pc/w/flags are pushed
//   pc_ip, w_ip, flags_ip: context saved on acknowledge
//   ret_ip               : CPU return; pops the top context
//   tos_*_op             : top-of-stack context (zero when empty)
//   depth_op             : stack occupancy
module irq_ctrl #(
  parameter int         N_IRQ       = 4,
  parameter int         PC_W        = 13,
  parameter int         DATA_W      = 8,
  parameter int         STACK_DEPTH = 4,
  parameter int         VEC_BASE    = 4,
  parameter int         VEC_STRIDE  = 2,
  parameter logic [7:0] ADDR_BASE   = 8'h03
) (
  input  logic              clk_ip,
  input  logic              reset_ip,
  input  logic [N_IRQ-1:0]  irq_ip,
  irq_ctrl_if.slave         bus,
  output logic              irq_req_op,
  output logic [PC_W-1:0]   irq_vec_op,
  input  logic              irq_ack_ip,
  input  logic [PC_W-1:0]   pc_ip,
  input  logic [DATA_W-1:0] w_ip,
  input  logic [1:0]        flags_ip,
  input  logic              ret_ip,
  output logic [PC_W-1:0]   tos_pc_op,
  output logic [DATA_W-1:0] tos_w_op,
  output logic [1:0]        tos_flags_op,
  output logic [4:0]        depth_op
);

  localparam int SIDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  // Pin synchroniser (two flops) plus one flop of history for edge detect.
  logic [N_IRQ-1:0] sync1_reg, sync2_reg, sync3_reg;
  logic [N_IRQ-1:0] rise;

  logic [N_IRQ-1:0] ie_reg, pend_reg, pend_next;
  logic             gie_reg, nest_reg, err_reg;
  logic             irq_req_reg;
  logic [PC_W-1:0]  irq_vec_reg;
  logic [2:0]       sel_reg;
  logic [4:0]       depth_reg;

  logic [PC_W-1:0]   stk_pc_reg    [STACK_DEPTH];
  logic [DATA_W-1:0] stk_w_reg     [STACK_DEPTH];
  logic [1:0]        stk_flags_reg [STACK_DEPTH];
  logic [2:0]        stk_src_reg   [STACK_DEPTH];

  logic [N_IRQ-1:0]  cand, ack_mask;
  logic [2:0]        sel_idx, tos_src;
  logic [SIDX_W-1:0] top_idx, wr_idx;
  logic              stack_empty, eligible, ack_fire, ret_fire, ret_bad, push_ok;
  logic              wr_ie, wr_pend, wr_ctrl;
  logic              unused_bits;

  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_edge
      assign rise[gi] = sync2_reg[gi] & ~sync3_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
      sync3_reg <= '0;
    end else begin
      sync1_reg <= irq_ip;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  assign wr_ie   = bus.wr_en_ip && (bus.addr_ip == ADDR_BASE);
  assign wr_pend = bus.wr_en_ip && (bus.addr_ip == ADDR_BASE + 8'd1);
  assign wr_ctrl = bus.wr_en_ip && (bus.addr_ip == ADDR_BASE + 8'd2);

  assign stack_empty = (depth_reg == 5'd0);
  assign top_idx     = SIDX_W'(depth_reg - 5'd1);
  assign tos_src     = stack_empty ? 3'd0 : stk_src_reg[top_idx];

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  assign cand = pend_reg & ie_reg;
  always_comb begin
    sel_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) sel_idx = 3'(i);
    end
  end

  assign eligible = gie_reg && (cand != '0) && (depth_reg < 5'(STACK_DEPTH)) &&
                    (stack_empty || (nest_reg && (sel_idx < tos_src)));

  assign ack_fire = irq_ack_ip && irq_req_reg;
  assign ret_fire = ret_ip && !stack_empty;
  assign ret_bad  = ret_ip && stack_empty;
  // Ack together with a return overwrites the top entry instead of pushing.
  assign push_ok  = ack_fire && (ret_fire || (depth_reg < 5'(STACK_DEPTH)));
  assign wr_idx   = ret_fire ? top_idx : SIDX_W'(depth_reg);
  assign ack_mask = N_IRQ'(1) << sel_reg;

  // A new edge is OR-ed in last so it beats both the W1C and the ack clear.
  always_comb begin
    pend_next = pend_reg;
    if (wr_pend)  pend_next = pend_next & ~bus.data_ip[N_IRQ-1:0];
    if (ack_fire) pend_next = pend_next & ~ack_mask;
    pend_next = pend_next | rise;
  end

  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      ie_reg      <= '0;
      pend_reg    <= '0;
      gie_reg     <= 1'b0;
      nest_reg    <= 1'b0;
      err_reg     <= 1'b0;
      irq_req_reg <= 1'b0;
      irq_vec_reg <= '0;
      sel_reg     <= '0;
      depth_reg   <= '0;
    end else begin
      pend_reg <= pend_next;
      if (wr_ie) ie_reg <= bus.data_ip[N_IRQ-1:0];
      if (wr_ctrl) begin
        gie_reg  <= bus.data_ip[0];
        nest_reg <= bus.data_ip[1];
      end
      if (ret_bad)                         err_reg <= 1'b1;
      else if (wr_ctrl && bus.data_ip[7])  err_reg <= 1'b0;

      // The acknowledged request is dropped for one cycle so a stale
      // eligibility (PEND not yet cleared) cannot re-raise it.
      irq_req_reg <= eligible && !ack_fire;
      irq_vec_reg <= (eligible && !ack_fire)
                     ? PC_W'(32'(VEC_BASE) + 32'(sel_idx) * 32'(VEC_STRIDE)) : '0;
      sel_reg     <= sel_idx;

      if (push_ok && !ret_fire)      depth_reg <= depth_reg + 5'd1;
      else if (ret_fire && !ack_fire) depth_reg <= depth_reg - 5'd1;
    end
  end

  // Context storage needs no reset: depth_reg gates every read of it.
  always_ff @(posedge clk_ip) begin
    if (push_ok) begin
      stk_pc_reg[wr_idx]    <= pc_ip;
      stk_w_reg[wr_idx]     <= w_ip;
      stk_flags_reg[wr_idx] <= flags_ip;
      stk_src_reg[wr_idx]   <= sel_reg;
    end
  end

  always_comb begin
    bus.data_op = '0;
    if (bus.addr_ip == ADDR_BASE)             bus.data_op = 8'(ie_reg);
    else if (bus.addr_ip == ADDR_BASE + 8'd1) bus.data_op = 8'(pend_reg);
    else if (bus.addr_ip == ADDR_BASE + 8'd2)
      bus.data_op = {err_reg, 1'b0, tos_src, 1'b0, nest_reg, gie_reg};
  end

  assign unused_bits = bus.rd_en_ip ^ (^bus.data_ip);

  assign irq_req_op   = irq_req_reg;
  assign irq_vec_op   = irq_vec_reg;
  assign depth_op     = depth_reg;
  assign tos_pc_op    = stack_empty ? '0 : stk_pc_reg[top_idx];
  assign tos_w_op     = stack_empty ? '0 : stk_w_reg[top_idx];
  assign tos_flags_op = stack_empty ? '0 : stk_flags_reg[top_idx];

endmodule
